// File: rtl/hilo_muldiv_if.sv
// HI/LO unit bundle: forwarding, WB write, engine control and read results.
// master = pipeline/hazard side, slave = HI/LO unit.
interface hilo_muldiv_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_FWD = 2
);
    logic [NUM_FWD-1:0]       fwd_en;
    logic [NUM_FWD*WIDTH-1:0] fwd_hi;
    logic [NUM_FWD*WIDTH-1:0] fwd_lo;
    logic                     wr_hi_en;
    logic                     wr_lo_en;
    logic [WIDTH-1:0]         wr_hi;
    logic [WIDTH-1:0]         wr_lo;
    logic                     start;
    logic [1:0]               op;
    logic [WIDTH-1:0]         src_a;
    logic [WIDTH-1:0]         src_b;
    logic                     flush;
    logic                     rd_req;
    logic [WIDTH-1:0]         hi_out;
    logic [WIDTH-1:0]         lo_out;
    logic                     busy;
    logic                     done;
    logic                     read_stall;

    modport master (
        output fwd_en, fwd_hi, fwd_lo, wr_hi_en, wr_lo_en, wr_hi, wr_lo,
        output start, op, src_a, src_b, flush, rd_req,
        input  hi_out, lo_out, busy, done, read_stall
    );

    modport slave (
        input  fwd_en, fwd_hi, fwd_lo, wr_hi_en, wr_lo_en, wr_hi, wr_lo,
        input  start, op, src_a, src_b, flush, rd_req,
        output hi_out, lo_out, busy, done, read_stall
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO registers with forwarded reads and a 1-bit/cycle
// MULT/MULTU/DIV/DIVU engine (shift-add multiply, restoring divide).
module hilo_muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int NUM_FWD = 2
) (
    input  logic         clk,
    input  logic         rst,
    hilo_muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic [WIDTH-1:0]   mb_q, mb_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // operand magnitudes captured at launch
    logic               sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   ma, mb;

    assign sgn   = ~bus.op[0];
    assign a_neg = sgn & bus.src_a[WIDTH-1];
    assign b_neg = sgn & bus.src_b[WIDTH-1];
    assign ma    = a_neg ? -bus.src_a : bus.src_a;
    assign mb    = b_neg ? -bus.src_b : bus.src_b;

    // one iteration of either algorithm on {hi_half, lo_half} of acc
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     div_sh, div_tr;
    logic               div_ok;
    logic [2*WIDTH-1:0] div_nxt;
    logic [2*WIDTH-1:0] step;

    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? mb_q : {WIDTH{1'b0}})};
    assign mul_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    assign div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_tr  = div_sh - {1'b0, mb_q};
    assign div_ok  = ~div_tr[WIDTH];
    assign div_nxt = {(div_ok ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], div_ok};
    assign step    = div_q ? div_nxt : mul_nxt;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    assign prod = neg_q ? -step : step;
    assign quo  = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
    assign rem  = rneg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        mb_d    = mb_q;
        a_d     = a_q;
        acc_d   = acc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    div_d   = bus.op[1];
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg & bus.op[1];
                    mb_d    = mb;
                    a_d     = bus.src_a;
                    acc_d   = {{WIDTH{1'b0}}, ma};
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        if (!div_q) begin
                            hi_d = prod[2*WIDTH-1:WIDTH];
                            lo_d = prod[WIDTH-1:0];
                        end else if (mb_q == '0) begin
                            hi_d = a_q;
                            lo_d = '1;
                        end else begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // WB is younger than the engine op, so it overrides
        if (bus.wr_hi_en) hi_d = bus.wr_hi;
        if (bus.wr_lo_en) lo_d = bus.wr_lo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            mb_q    <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            mb_q    <= mb_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    logic [WIDTH-1:0] hi_rd, lo_rd;

    // scan oldest to youngest so the lowest enabled slot wins
    always_comb begin
        hi_rd = bus.wr_hi_en ? bus.wr_hi : hi_q;
        lo_rd = bus.wr_lo_en ? bus.wr_lo : lo_q;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (bus.fwd_en[i]) begin
                hi_rd = bus.fwd_hi[i*WIDTH +: WIDTH];
                lo_rd = bus.fwd_lo[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.hi_out     = hi_rd;
    assign bus.lo_out     = lo_rd;
    assign bus.busy       = (state_q == S_RUN);
    assign bus.done       = done_q;
    assign bus.read_stall = bus.rd_req & (state_q == S_RUN);
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: reset, mul/div results,
// divide-by-zero, forwarding priority, WB override, flush.
module tb_hilo_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hilo_muldiv_if #(.WIDTH(32), .NUM_FWD(2)) bus();

    hilo_muldiv_unit #(.WIDTH(32), .NUM_FWD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // launch op, watch 40 cycles; optional WB HI write on completion edge
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input bit wb_hi);
        int nb;
        int nd;
        nb = 0;
        nd = 0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) nb++;
            if (bus.done) nd++;
            bus.start    = (i == 5);
            bus.wr_hi_en = wb_hi && (i == 31);
            bus.wr_hi    = 32'h0BAD_CAFE;
            tick();
        end
        bus.start    = 1'b0;
        bus.wr_hi_en = 1'b0;
        chk({tag, "_busy"}, 64'(nb), 64'd32);
        chk({tag, "_done"}, 64'(nd), 64'd1);
        chk({tag, "_hi"}, 64'(bus.hi_out), 64'(ehi));
        chk({tag, "_lo"}, 64'(bus.lo_out), 64'(elo));
    endtask

    initial begin
        int nd;
        rst          = 1'b1;
        bus.fwd_en   = '0;
        bus.fwd_hi   = '0;
        bus.fwd_lo   = '0;
        bus.wr_hi_en = 1'b0;
        bus.wr_lo_en = 1'b0;
        bus.wr_hi    = '0;
        bus.wr_lo    = '0;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.flush    = 1'b0;
        bus.rd_req   = 1'b1;
        tick();
        tick();
        chk("rst_hi", 64'(bus.hi_out), 64'd0);
        chk("rst_lo", 64'(bus.lo_out), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_stall", 64'(bus.read_stall), 64'd0);
        rst        = 1'b0;
        bus.rd_req = 1'b0;
        tick();

        run_op("mult", 2'b00, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("mult2", 2'b00, 32'd7, 32'hFFFF_FFFA,
               32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
        run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'd2,
               32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("divu", 2'b11, 32'd100, 32'd7,
               32'h0000_0002, 32'h0000_000E, 1'b0);
        run_op("div", 2'b10, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu0", 2'b11, 32'd5, 32'd0,
               32'h0000_0005, 32'hFFFF_FFFF, 1'b0);
        run_op("div0", 2'b10, 32'hFFFF_FFFB, 32'd0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
        run_op("wbcmp", 2'b11, 32'd100, 32'd7,
               32'h0BAD_CAFE, 32'h0000_000E, 1'b1);

        // forwarding priority, combinational within one cycle
        bus.fwd_hi = {32'hBBBB_0001, 32'hAAAA_0000};
        bus.fwd_lo = {32'hBBBB_1001, 32'hAAAA_1000};
        bus.wr_hi  = 32'h1234_5678;
        bus.fwd_en = 2'b11;
        #1;
        chk("fwd11_hi", 64'(bus.hi_out), 64'h0000_0000_AAAA_0000);
        chk("fwd11_lo", 64'(bus.lo_out), 64'h0000_0000_AAAA_1000);
        bus.fwd_en = 2'b10;
        #1;
        chk("fwd10_hi", 64'(bus.hi_out), 64'h0000_0000_BBBB_0001);
        chk("fwd10_lo", 64'(bus.lo_out), 64'h0000_0000_BBBB_1001);
        bus.fwd_en   = 2'b00;
        bus.wr_hi_en = 1'b1;
        #1;
        chk("fwdwb_hi", 64'(bus.hi_out), 64'h0000_0000_1234_5678);
        chk("fwdwb_lo", 64'(bus.lo_out), 64'h0000_0000_0000_000E);
        bus.wr_hi_en = 1'b0;
        #1;
        chk("fwdreg_hi", 64'(bus.hi_out), 64'h0000_0000_0BAD_CAFE);

        // WB LO commit into the register
        bus.wr_lo_en = 1'b1;
        bus.wr_lo    = 32'h5555_AAAA;
        tick();
        bus.wr_lo_en = 1'b0;
        #1;
        chk("wblo_reg", 64'(bus.lo_out), 64'h0000_0000_5555_AAAA);

        // flush and start together: not accepted
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 2'b10;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        chk("fsflush_busy", 64'(bus.busy), 64'd0);

        // flush on the 10th busy cycle of DIV
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        bus.rd_req = 1'b1;
        #1;
        chk("stall", 64'(bus.read_stall), 64'd1);
        chk("flush_busy10", 64'(bus.busy), 64'd1);
        chk("nopartial_hi", 64'(bus.hi_out), 64'h0000_0000_0BAD_CAFE);
        bus.rd_req = 1'b0;
        bus.flush  = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) nd++;
            tick();
        end
        chk("flush_nodone", 64'(nd), 64'd0);
        chk("flush_hi", 64'(bus.hi_out), 64'h0000_0000_0BAD_CAFE);
        chk("flush_lo", 64'(bus.lo_out), 64'h0000_0000_5555_AAAA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
